// File: rtl/id_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: flag bit positions,
// ALU command encodings, field widths and the per-edge update decision.
package id_stage_reg_pkg;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam int FLAGS_W      = 4;
  localparam int WORD_W       = 32;
  localparam int EXE_CMD_W    = 4;
  localparam int SHIFT_OP_W   = 12;
  localparam int SIGNED_IMM_W = 24;
  localparam int REG_ADDR_W   = 4;

  localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
  localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
  localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

  typedef struct packed {
    logic [EXE_CMD_W-1:0]    exe_cmd;
    logic [WORD_W-1:0]       pc;
    logic [WORD_W-1:0]       val_rn;
    logic [WORD_W-1:0]       val_rm;
    logic                    imm;
    logic [SHIFT_OP_W-1:0]   shift_operand;
    logic [SIGNED_IMM_W-1:0] signed_imm_24;
    logic [REG_ADDR_W-1:0]   dest;
  } ex_data_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_FLUSH
  } stage_act_t;

  // A taken branch must win over a hazard stall, or the bubble would be lost.
  function automatic stage_act_t stage_action(input logic flush, input logic freeze);
    if (flush)       return ACT_FLUSH;
    else if (freeze) return ACT_HOLD;
    else             return ACT_LOAD;
  endfunction

endpackage

// File: rtl/id_stage_reg_if.sv
// ID-side instruction bundle in, EX-side registered bundle out.
interface id_stage_reg_if;
  import id_stage_reg_pkg::*;

  logic                    id_valid;
  logic                    cond_valid;
  logic                    wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [EXE_CMD_W-1:0]    exe_cmd_in;
  logic [WORD_W-1:0]       pc_in, val_rn_in, val_rm_in;
  logic                    imm_in;
  logic [SHIFT_OP_W-1:0]   shift_operand_in;
  logic [SIGNED_IMM_W-1:0] signed_imm_24_in;
  logic [REG_ADDR_W-1:0]   dest_in;

  logic                    valid_out;
  logic                    wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
  logic [EXE_CMD_W-1:0]    exe_cmd_out;
  logic [WORD_W-1:0]       pc_out, val_rn_out, val_rm_out;
  logic                    imm_out;
  logic [SHIFT_OP_W-1:0]   shift_operand_out;
  logic [SIGNED_IMM_W-1:0] signed_imm_24_out;
  logic [REG_ADDR_W-1:0]   dest_out;
  logic [FLAGS_W-1:0]      status_exe_out;

  modport master (
    output id_valid, cond_valid,
    output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in,
    output exe_cmd_in, pc_in, val_rn_in, val_rm_in,
    output imm_in, shift_operand_in, signed_imm_24_in, dest_in,
    input  valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
    input  exe_cmd_out, pc_out, val_rn_out, val_rm_out,
    input  imm_out, shift_operand_out, signed_imm_24_out, dest_out,
    input  status_exe_out
  );

  modport slave (
    input  id_valid, cond_valid,
    input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in,
    input  exe_cmd_in, pc_in, val_rn_in, val_rm_in,
    input  imm_in, shift_operand_in, signed_imm_24_in, dest_in,
    output valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
    output exe_cmd_out, pc_out, val_rn_out, val_rm_out,
    output imm_out, shift_operand_out, signed_imm_24_out, dest_out,
    output status_exe_out
  );
endinterface

// File: rtl/id_stage_reg_status_reg.sv
// Processor flag register {c,n,v,z}; a same-cycle write is forwarded to the
// output so the condition check never sees stale flags.
module status_reg
  import id_stage_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sr_wr_en,
  input  logic [FLAGS_W-1:0] sr_flags_in,
  output logic [FLAGS_W-1:0] status_out
);

  logic [FLAGS_W-1:0] flags_q, flags_d;

  always_comb begin
    flags_d    = sr_wr_en ? sr_flags_in : flags_q;
    status_out = flags_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags_q <= '0;
    else      flags_q <= flags_d;
  end

endmodule

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register with flush/freeze control, condition squash,
// saturating squash counter and the processor status register.
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter int KILL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  sr_wr_en,
  input  logic [FLAGS_W-1:0]    sr_flags_in,
  output logic [FLAGS_W-1:0]    status_out,
  output logic [KILL_CNT_W-1:0] kill_cnt,
  id_stage_reg_if.slave         bus
);

  ctrl_t                 ctrl_in, ctrl_q, ctrl_d;
  ex_data_t              data_in, data_q, data_d;
  logic                  valid_q, valid_d;
  logic [FLAGS_W-1:0]    status_exe_q, status_exe_d;
  logic [KILL_CNT_W-1:0] kill_cnt_q, kill_cnt_d;
  logic                  squash;
  logic                  issue;

  status_reg u_status_reg (
    .clk         (clk),
    .rst         (rst),
    .sr_wr_en    (sr_wr_en),
    .sr_flags_in (sr_flags_in),
    .status_out  (status_out)
  );

  assign ctrl_in = '{wb_en:    bus.wb_en_in,
                     mem_r_en: bus.mem_r_en_in,
                     mem_w_en: bus.mem_w_en_in,
                     b:        bus.b_in,
                     s:        bus.s_in};

  assign data_in = '{exe_cmd:       bus.exe_cmd_in,
                     pc:            bus.pc_in,
                     val_rn:        bus.val_rn_in,
                     val_rm:        bus.val_rm_in,
                     imm:           bus.imm_in,
                     shift_operand: bus.shift_operand_in,
                     signed_imm_24: bus.signed_imm_24_in,
                     dest:          bus.dest_in};

  assign squash = bus.id_valid & ~bus.cond_valid;
  assign issue  = bus.id_valid &  bus.cond_valid;

  always_comb begin
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    valid_d      = valid_q;
    status_exe_d = status_exe_q;
    kill_cnt_d   = kill_cnt_q;
    case (stage_action(flush, freeze))
      ACT_FLUSH: begin
        ctrl_d       = '0;
        data_d       = '0;
        valid_d      = 1'b0;
        status_exe_d = '0;
      end
      ACT_HOLD: begin
      end
      default: begin
        // Datapath is copied even for bubbles; only the control bits gate effects.
        data_d       = data_in;
        status_exe_d = status_out;
        valid_d      = issue;
        ctrl_d       = issue ? ctrl_in : '0;
        if (squash && (kill_cnt_q != {KILL_CNT_W{1'b1}}))
          kill_cnt_d = kill_cnt_q + KILL_CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      status_exe_q <= '0;
      kill_cnt_q   <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      status_exe_q <= status_exe_d;
      kill_cnt_q   <= kill_cnt_d;
    end
  end

  assign bus.valid_out         = valid_q;
  assign bus.wb_en_out         = ctrl_q.wb_en;
  assign bus.mem_r_en_out      = ctrl_q.mem_r_en;
  assign bus.mem_w_en_out      = ctrl_q.mem_w_en;
  assign bus.b_out             = ctrl_q.b;
  assign bus.s_out             = ctrl_q.s;
  assign bus.exe_cmd_out       = data_q.exe_cmd;
  assign bus.pc_out            = data_q.pc;
  assign bus.val_rn_out        = data_q.val_rn;
  assign bus.val_rm_out        = data_q.val_rm;
  assign bus.imm_out           = data_q.imm;
  assign bus.shift_operand_out = data_q.shift_operand;
  assign bus.signed_imm_24_out = data_q.signed_imm_24;
  assign bus.dest_out          = data_q.dest;
  assign bus.status_exe_out    = status_exe_q;
  assign kill_cnt              = kill_cnt_q;

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed vector bench for id_stage_reg: table of load/squash/freeze/flush
// steps followed by saturation and asynchronous-reset sequences.
module tb_id_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        sr_wr_en = 1'b0;
  logic [3:0]  sr_flags_in = '0;
  logic [3:0]  status_out;
  logic [15:0] kill_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  id_stage_reg_if bus ();

  id_stage_reg #(.KILL_CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .flush       (flush),
    .sr_wr_en    (sr_wr_en),
    .sr_flags_in (sr_flags_in),
    .status_out  (status_out),
    .kill_cnt    (kill_cnt),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, fz, iv, cv;
    logic [4:0]  ctrl;      // {wb, mem_r, mem_w, b, s}
    logic [3:0]  cmd;
    logic [31:0] pc;
    logic [3:0]  dest;
    logic        srw;
    logic [3:0]  srf;
    logic [3:0]  e_status;  // status_out before the edge
    logic        e_valid;
    logic [4:0]  e_ctrl;
    logic [3:0]  e_cmd;
    logic [31:0] e_pc;
    logic [3:0]  e_dest;
    logic [3:0]  e_sexe;
    logic [15:0] e_kill;
  } vec_t;

  vec_t vecs [12];

  // Secondary operand fields are derived from pc so one hand value covers them.
  function automatic logic [31:0] rn_of(input logic [31:0] pc);
    return (pc == 0) ? 32'h0 : (pc ^ 32'h5A5A_0000);
  endfunction
  function automatic logic [31:0] rm_of(input logic [31:0] pc);
    return (pc == 0) ? 32'h0 : (pc + 32'h100);
  endfunction
  function automatic logic [36:0] aux_of(input logic [31:0] pc);
    return (pc == 0) ? 37'h0 : {pc[2], pc[11:0] ^ 12'hABC, pc[23:0] ^ 24'h00F0F0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic fl, input logic fz, input logic iv, input logic cv,
                       input logic [4:0] ctrl, input logic [3:0] cmd, input logic [31:0] pc,
                       input logic [3:0] dest, input logic srw, input logic [3:0] srf);
    flush                 = fl;
    freeze                = fz;
    bus.id_valid          = iv;
    bus.cond_valid        = cv;
    {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.b_in, bus.s_in} = ctrl;
    bus.exe_cmd_in        = cmd;
    bus.pc_in             = pc;
    bus.val_rn_in         = rn_of(pc);
    bus.val_rm_in         = rm_of(pc);
    {bus.imm_in, bus.shift_operand_in, bus.signed_imm_24_in} = aux_of(pc);
    bus.dest_in           = dest;
    sr_wr_en              = srw;
    sr_flags_in           = srf;
  endtask

  function automatic logic [4:0] ctrl_out();
    return {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.b_out, bus.s_out};
  endfunction

  task automatic check_outputs(input string tag, input logic e_valid, input logic [4:0] e_ctrl,
                               input logic [3:0] e_cmd, input logic [31:0] e_pc,
                               input logic [3:0] e_dest, input logic [3:0] e_sexe,
                               input logic [15:0] e_kill);
    check({tag, ".valid"}, 64'(bus.valid_out), 64'(e_valid));
    check({tag, ".ctrl"},  64'(ctrl_out()), 64'(e_ctrl));
    check({tag, ".cmd"},   64'(bus.exe_cmd_out), 64'(e_cmd));
    check({tag, ".pc"},    64'(bus.pc_out), 64'(e_pc));
    check({tag, ".dest"},  64'(bus.dest_out), 64'(e_dest));
    check({tag, ".sexe"},  64'(bus.status_exe_out), 64'(e_sexe));
    check({tag, ".kill"},  64'(kill_cnt), 64'(e_kill));
    check({tag, ".rn"},    64'(bus.val_rn_out), 64'(rn_of(e_pc)));
    check({tag, ".rm"},    64'(bus.val_rm_out), 64'(rm_of(e_pc)));
    check({tag, ".aux"},   64'({bus.imm_out, bus.shift_operand_out, bus.signed_imm_24_out}),
          64'(aux_of(e_pc)));
  endtask

  initial begin
    //          fl fz iv cv ctrl      cmd   pc     dest  srw srf     | st     v  ctrl      cmd   pc     dest  sexe    kill
    vecs[0]  = '{0,0,1,1,5'b10000,4'h2,32'h10,4'h5,0,4'b0000, 4'b0000,1,5'b10000,4'h2,32'h10,4'h5,4'b0000,16'd0};
    vecs[1]  = '{0,0,1,0,5'b00100,4'h4,32'h20,4'h3,0,4'b0000, 4'b0000,0,5'b00000,4'h4,32'h20,4'h3,4'b0000,16'd1};
    vecs[2]  = '{0,0,1,1,5'b00001,4'h3,32'h24,4'h1,1,4'b0001, 4'b0001,1,5'b00001,4'h3,32'h24,4'h1,4'b0001,16'd1};
    vecs[3]  = '{0,1,1,0,5'b11111,4'hF,32'hFF,4'hF,0,4'b0000, 4'b0001,1,5'b00001,4'h3,32'h24,4'h1,4'b0001,16'd1};
    vecs[4]  = '{0,1,0,0,5'b01100,4'h7,32'h64,4'h6,1,4'b1000, 4'b1000,1,5'b00001,4'h3,32'h24,4'h1,4'b0001,16'd1};
    vecs[5]  = '{0,1,1,1,5'b11111,4'h8,32'h68,4'h8,0,4'b0000, 4'b1000,1,5'b00001,4'h3,32'h24,4'h1,4'b0001,16'd1};
    vecs[6]  = '{1,1,1,0,5'b11111,4'hF,32'h30,4'hF,0,4'b0000, 4'b1000,0,5'b00000,4'h0,32'h0, 4'h0,4'b0000,16'd1};
    vecs[7]  = '{1,0,1,1,5'b10101,4'h2,32'h34,4'h4,1,4'b0110, 4'b0110,0,5'b00000,4'h0,32'h0, 4'h0,4'b0000,16'd1};
    vecs[8]  = '{0,0,0,1,5'b11111,4'h6,32'h40,4'h7,0,4'b0000, 4'b0110,0,5'b00000,4'h6,32'h40,4'h7,4'b0110,16'd1};
    vecs[9]  = '{0,0,1,1,5'b11111,4'h9,32'h44,4'hE,1,4'b1111, 4'b1111,1,5'b11111,4'h9,32'h44,4'hE,4'b1111,16'd1};
    vecs[10] = '{0,0,1,0,5'b01010,4'h5,32'h48,4'h2,0,4'b0000, 4'b1111,0,5'b00000,4'h5,32'h48,4'h2,4'b1111,16'd2};
    vecs[11] = '{0,0,1,1,5'b01010,4'h1,32'h4C,4'h0,0,4'b0000, 4'b1111,1,5'b01010,4'h1,32'h4C,4'h0,4'b1111,16'd2};

    drive(0, 0, 0, 0, 5'b0, 4'h0, 32'h0, 4'h0, 0, 4'b0);
    #12;
    check("reset.status", 64'(status_out), 64'h0);
    check_outputs("reset", 0, 5'b0, 4'h0, 32'h0, 4'h0, 4'h0, 16'd0);
    $display("reset: valid=%0b status=%0h kill=%0d", bus.valid_out, status_out, kill_cnt);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].fz, vecs[i].iv, vecs[i].cv, vecs[i].ctrl, vecs[i].cmd,
            vecs[i].pc, vecs[i].dest, vecs[i].srw, vecs[i].srf);
      #1;
      check($sformatf("v%0d.status", i), 64'(status_out), 64'(vecs[i].e_status));
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_ctrl, vecs[i].e_cmd,
                    vecs[i].e_pc, vecs[i].e_dest, vecs[i].e_sexe, vecs[i].e_kill);
      $display("vec %0d: fl=%0b fz=%0b iv=%0b cv=%0b -> valid=%0b ctrl=%05b pc=%0h sexe=%04b kill=%0d",
               i, vecs[i].fl, vecs[i].fz, vecs[i].iv, vecs[i].cv, bus.valid_out, ctrl_out(),
               bus.pc_out, bus.status_exe_out, kill_cnt);
    end

    // Saturation: 65536 more squashes starting from a count of 2.
    @(negedge clk);
    drive(0, 0, 1, 0, 5'b11111, 4'h2, 32'h50, 4'h3, 0, 4'b0);
    repeat (65536) @(posedge clk);
    #1;
    check("sat.kill", 64'(kill_cnt), 64'hFFFF);
    check("sat.valid", 64'(bus.valid_out), 64'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("sat.kill_hold", 64'(kill_cnt), 64'hFFFF);
    $display("saturation: kill=%0h", kill_cnt);

    // Asynchronous reset between edges with a live instruction and flags set.
    @(negedge clk);
    drive(0, 0, 1, 1, 5'b10000, 4'h2, 32'h90, 4'hA, 1, 4'b1010);
    @(posedge clk);
    #1;
    check("pre_rst.valid", 64'(bus.valid_out), 64'h1);
    @(negedge clk);
    sr_wr_en = 1'b0;
    #1;
    check("pre_rst.status", 64'(status_out), 64'hA);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst.status", 64'(status_out), 64'h0);
    check_outputs("async_rst", 0, 5'b0, 4'h0, 32'h0, 4'h0, 4'h0, 16'd0);
    $display("async reset: valid=%0b status=%0h kill=%0d", bus.valid_out, status_out, kill_cnt);

    // Reset held across an edge while freeze is up; first edge after release loads.
    @(negedge clk);
    drive(0, 1, 1, 1, 5'b11000, 4'h5, 32'h80, 4'h9, 0, 4'b0);
    @(posedge clk);
    #1;
    check("rst_frz.pc", 64'(bus.pc_out), 64'h0);
    @(negedge clk);
    rst    = 1'b1;
    freeze = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1, 5'b11000, 4'h5, 32'h80, 4'h9, 4'h0, 16'd0);
    $display("post reset load: valid=%0b pc=%0h ctrl=%05b", bus.valid_out, bus.pc_out, ctrl_out());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
